alu_program_loader: RTL and testbench

- Writer side of the ALU instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and packs every 3 bytes into a 19-bit word {op[2:0], A[7:0], B[7:0]}.
- Stores the words in a 64-entry RAM.
- Exposes an asynchronous read port with the same address-to-word semantics as the instruction ROM, so the program counter and field splitter can sit on it unchanged.

---
 rtl/alu_program_loader.sv | 128 ++++++++++++
 tb/tb_alu_program_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_program_loader.sv
// Byte-stream loader for the ALU instruction memory: frames a header plus 3-byte words into a
// RAM whose asynchronous read port hides everything beyond the committed program length.
module alu_program_loader #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WORD_W = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              load_done,
    output logic              error,
    output logic              busy,
    output logic [ADDR_W:0]   prog_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    typedef enum logic [2:0] {StIdle, StHdr, StOp, StImmA, StImmB, StDone, StErr} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     prog_len_q, prog_len_d;
    logic [2:0]          op_q, op_d;
    logic [7:0]          a_q, a_d;
    logic                mem_we;
    logic                accept;
    logic                hdr_ok;
    logic [WORD_W-1:0]   mem [DEPTH];

    assign busy      = (state_q == StHdr) || (state_q == StOp) ||
                       (state_q == StImmA) || (state_q == StImmB);
    assign load_done = (state_q == StDone);
    assign error     = (state_q == StErr);
    assign in_ready  = busy && !start;
    assign accept    = in_valid && in_ready;
    assign prog_len  = prog_len_q;
    assign hdr_ok    = (in_data != 8'd0) && (32'(in_data) <= DEPTH);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        prog_len_d = prog_len_q;
        op_d       = op_q;
        a_d        = a_q;
        mem_we     = 1'b0;
        if (start) begin
            // start wins over any byte presented in the same cycle
            state_d    = StHdr;
            wr_ptr_d   = '0;
            word_cnt_d = '0;
            n_d        = '0;
            prog_len_d = '0;
        end else if (accept) begin
            unique case (state_q)
                StHdr: begin
                    if (hdr_ok) begin
                        n_d     = (ADDR_W+1)'(in_data);
                        state_d = StOp;
                    end else begin
                        state_d = StErr;
                    end
                end
                StOp: begin
                    if (in_data[7:3] != 5'd0) begin
                        state_d = StErr;
                    end else begin
                        op_d    = in_data[2:0];
                        state_d = StImmA;
                    end
                end
                StImmA: begin
                    a_d     = in_data;
                    state_d = StImmB;
                end
                StImmB: begin
                    mem_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if ((word_cnt_q + 1'b1) == n_q) begin
                        state_d    = StDone;
                        prog_len_d = n_q;
                    end else begin
                        state_d = StOp;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            word_cnt_q <= '0;
            n_q        <= '0;
            prog_len_q <= '0;
            op_q       <= '0;
            a_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            word_cnt_q <= word_cnt_d;
            n_q        <= n_d;
            prog_len_q <= prog_len_d;
            op_q       <= op_d;
            a_q        <= a_d;
        end
    end

    // RAM contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= {op_q, a_q, in_data};
        end
    end

    assign rd_data = ({1'b0, rd_addr} < prog_len_q) ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_alu_program_loader.sv
// Self-checking bench for alu_program_loader: table of framed loads plus hand-written
// sequences for backpressure, full memory, restart and asynchronous reset.
module tb_alu_program_loader;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned WORD_W = 19;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              load_done;
    logic              error;
    logic              busy;
    logic [ADDR_W:0]   prog_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;

    alu_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .load_done(load_done),
        .error    (error),
        .busy     (busy),
        .prog_len (prog_len),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] exp;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        string        name;
        int           nb;
        logic [55:0]  b;
        logic         exp_err;
        logic [6:0]   exp_len;
        logic [18:0]  w0;
        logic [18:0]  w1;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; in_ready is sampled before the next edge.
    task automatic step(input logic s, input logic v, input logic [7:0] d, output logic rdy);
        start    = s;
        in_valid = v;
        in_data  = d;
        #1;
        rdy = in_ready;
        @(posedge clock);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic push_rd(input int addr, input logic [WORD_W-1:0] exp);
        rd_exp_t e;
        e.addr = ADDR_W'(addr);
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain_sb(input string name);
        rd_exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            #1;
            check($sformatf("%s_rd%0d", name, e.addr), 32'(rd_data), 32'(e.exp));
        end
    endtask

    function automatic vec_t mk(string name, int nb, logic [55:0] b, logic exp_err,
                                logic [6:0] exp_len, logic [18:0] w0, logic [18:0] w1);
        vec_t v;
        v.name = name; v.nb = nb; v.b = b; v.exp_err = exp_err;
        v.exp_len = exp_len; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    initial begin
        logic              rdy;
        int                rc;
        logic [7:0]        iv;
        logic [7:0]        bp_bytes [7];
        logic [WORD_W-1:0] wexp;

        vecs[0] = mk("two_word", 7, {8'h02, 8'h00, 8'h0B, 8'h89, 8'h01, 8'h0E, 8'h4C},
                     1'b0, 7'd2, 19'h00B89, 19'h10E4C);
        vecs[1] = mk("hdr00", 1, {8'h00, 48'h0}, 1'b1, 7'd0, 19'h0, 19'h0);
        vecs[2] = mk("hdr41", 1, {8'h41, 48'h0}, 1'b1, 7'd0, 19'h0, 19'h0);
        vecs[3] = mk("bad_op", 2, {8'h01, 8'h08, 40'h0}, 1'b1, 7'd0, 19'h0, 19'h0);
        vecs[4] = mk("one_word", 4, {8'h01, 8'h07, 8'hFF, 8'h01, 24'h0},
                     1'b0, 7'd1, 19'h7FF01, 19'h0);
        vecs[5] = mk("one_word_b", 4, {8'h01, 8'h00, 8'hAB, 8'hCD, 24'h0},
                     1'b0, 7'd1, 19'h0ABCD, 19'h0);

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_addr = '0;
        #1;
        check("rst_flags", 32'({in_ready, load_done, error, busy}), 32'(0));
        check("rst_len", 32'(prog_len), 32'(0));
        check("rst_rd", 32'(rd_data), 32'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (vecs[vi]) begin
            step(1'b1, 1'b1, 8'hEE, rdy);
            check({vecs[vi].name, "_start_rdy"}, 32'(rdy), 32'(0));
            check({vecs[vi].name, "_start_flags"}, 32'({busy, load_done, error}), 32'(3'b100));
            check({vecs[vi].name, "_start_len"}, 32'(prog_len), 32'(0));
            rc = 0;
            for (int k = 0; k < vecs[vi].nb; k++) begin
                step(1'b0, 1'b1, vecs[vi].b[55-8*k -: 8], rdy);
                if (rdy) rc++;
            end
            check({vecs[vi].name, "_rdy_cnt"}, 32'(rc), 32'(vecs[vi].nb));
            in_valid = 1'b1;
            #1;
            check({vecs[vi].name, "_flags"}, 32'({in_ready, busy, load_done, error}),
                  32'({1'b0, 1'b0, !vecs[vi].exp_err, vecs[vi].exp_err}));
            in_valid = 1'b0;
            check({vecs[vi].name, "_len"}, 32'(prog_len), 32'(vecs[vi].exp_len));
            push_rd(0, (vecs[vi].exp_len > 0) ? vecs[vi].w0 : 19'h0);
            push_rd(1, (vecs[vi].exp_len > 1) ? vecs[vi].w1 : 19'h0);
            push_rd(2, 19'h0);
            drain_sb(vecs[vi].name);
        end

        // Full memory: word i = {i[2:0], i, ~i}
        step(1'b1, 1'b0, 8'h00, rdy);
        step(1'b0, 1'b1, 8'h40, rdy);
        for (int i = 0; i < 64; i++) begin
            iv = 8'(i);
            step(1'b0, 1'b1, {5'b0, iv[2:0]}, rdy);
            step(1'b0, 1'b1, iv, rdy);
            step(1'b0, 1'b1, ~iv, rdy);
            wexp = {iv[2:0], iv, ~iv};
            push_rd(i, wexp);
        end
        check("full_len", 32'(prog_len), 32'(64));
        check("full_done", 32'({load_done, busy, error}), 32'(3'b100));
        step(1'b0, 1'b1, 8'h07, rdy);
        check("full_extra_rdy", 32'(rdy), 32'(0));
        drain_sb("full");

        // Backpressure: valid low on alternate cycles with junk data
        bp_bytes = '{8'h02, 8'h00, 8'h0B, 8'h89, 8'h01, 8'h0E, 8'h4C};
        step(1'b1, 1'b0, 8'h00, rdy);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0, 8'($urandom), rdy);
            check($sformatf("bp_done_gap%0d", k), 32'(load_done), 32'(0));
            step(1'b0, 1'b1, bp_bytes[k], rdy);
            check($sformatf("bp_done_byte%0d", k), 32'(load_done), 32'(k == 6));
        end
        check("bp_len", 32'(prog_len), 32'(2));
        push_rd(0, 19'h00B89);
        push_rd(1, 19'h10E4C);
        push_rd(2, 19'h0);
        drain_sb("bp");

        // Restart after 4 bytes: the byte alongside start must not be consumed
        step(1'b1, 1'b0, 8'h00, rdy);
        step(1'b0, 1'b1, 8'h02, rdy);
        step(1'b0, 1'b1, 8'h00, rdy);
        step(1'b0, 1'b1, 8'h0B, rdy);
        step(1'b0, 1'b1, 8'h89, rdy);
        step(1'b1, 1'b1, 8'h01, rdy);
        check("rs_rdy", 32'(rdy), 32'(0));
        check("rs_state", 32'({busy, load_done, error}), 32'(3'b100));
        check("rs_len", 32'(prog_len), 32'(0));
        step(1'b0, 1'b1, 8'h01, rdy);
        step(1'b0, 1'b1, 8'h05, rdy);
        step(1'b0, 1'b1, 8'h12, rdy);
        step(1'b0, 1'b1, 8'h34, rdy);
        check("rs_done", 32'({load_done, prog_len}), 32'({1'b1, 7'd1}));
        push_rd(0, 19'h51234);
        push_rd(1, 19'h0);
        drain_sb("rs");

        // Asynchronous reset mid-word
        step(1'b1, 1'b0, 8'h00, rdy);
        step(1'b0, 1'b1, 8'h01, rdy);
        step(1'b0, 1'b1, 8'h03, rdy);
        step(1'b0, 1'b1, 8'hAA, rdy);
        check("ar_pre_busy", 32'(busy), 32'(1));
        in_valid = 1'b1;
        in_data  = 8'h55;
        reset    = 1'b1;
        #1;
        check("ar_flags", 32'({in_ready, load_done, error, busy}), 32'(0));
        check("ar_len", 32'(prog_len), 32'(0));
        rd_addr = '0;
        #1;
        check("ar_rd", 32'(rd_data), 32'(0));
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("ar_idle", 32'({in_ready, load_done, error, busy}), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
